// File: rtl/demux_pkg.sv
// Shared definitions for the 1:8 demux dispatch controller.
//   NCH      number of demux output channels
//   SEL_W    width of the channel select
//   state_e  dispatcher FSM states
//   onehot8  select -> one-hot channel decode
package demux_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic logic [NCH-1:0] onehot8(input logic [SEL_W-1:0] s);
    logic [NCH-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Synchronous FIFO holding tagged {dest,data} words for the dispatcher.
//   clk, rst_n  clock and synchronous active-low reset (empties the FIFO)
//   push, din   write request and word; ignored while full (no bypass)
//   pop         read request; ignored while empty
//   full, empty occupancy flags, registered
//   dout        head-of-queue word (valid when !empty)
module dispatch_fifo #(
  parameter int unsigned W     = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Upstream feeder for the 1:8 demultiplexer stage. Buffers tagged words and
// presents them one at a time as registered sel/strobe/data_out, holding each
// until the addressed sink is ready or the wait times out (word dropped).
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  upstream stream handshake (in_ready = FIFO not full)
//   in_dest, in_data   destination channel and payload
//   sel, strobe        registered demux select and enable
//   data_out           registered payload for the selected channel
//   ch_valid           one-hot channel valid decoded from registers
//   ch_ready           per-channel sink ready
//   err_timeout        one-cycle pulse after a word is dropped
//   drop_cnt           dropped words, saturating
//   xfer_cnt           completed transfers, wrapping
module demux_dispatch_ctrl
  import demux_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_dest,
  input  logic [DW-1:0]    in_data,
  output logic [SEL_W-1:0] sel,
  output logic             strobe,
  output logic [DW-1:0]    data_out,
  output logic [NCH-1:0]   ch_valid,
  input  logic [NCH-1:0]   ch_ready,
  output logic             err_timeout,
  output logic [7:0]       drop_cnt,
  output logic [15:0]      xfer_cnt
);

  localparam int unsigned     WCW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit              TO_EN     = (TIMEOUT != 0);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DW-1:0]       data_q, data_d;
  logic                strobe_q, strobe_d;
  logic [WCW-1:0]      wait_q, wait_d;
  logic                err_q, err_d;
  logic [7:0]          drop_q, drop_d;
  logic [15:0]         xfer_q, xfer_d;

  logic                fifo_pop, fifo_full, fifo_empty;
  logic [SEL_W+DW-1:0] head_w;
  logic                advance;

  dispatch_fifo #(
    .W     (SEL_W + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   ({in_dest, in_data}),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (head_w)
  );

  assign in_ready    = !fifo_full;
  assign sel         = sel_q;
  assign strobe      = strobe_q;
  assign data_out    = data_q;
  assign ch_valid    = strobe_q ? onehot8(sel_q) : '0;
  assign err_timeout = err_q;
  assign drop_cnt    = drop_q;
  assign xfer_cnt    = xfer_q;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    data_d   = data_q;
    strobe_d = strobe_q;
    wait_d   = wait_q;
    err_d    = 1'b0;
    drop_d   = drop_q;
    xfer_d   = xfer_q;
    fifo_pop = 1'b0;
    advance  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sel_d    = head_w[SEL_W+DW-1:DW];
          data_d   = head_w[DW-1:0];
          strobe_d = 1'b1;
          wait_d   = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (ch_ready[sel_q]) begin
          xfer_d  = xfer_q + 16'd1;
          advance = 1'b1;
        end else if (TO_EN && (wait_q == WAIT_LAST)) begin
          err_d   = 1'b1;
          if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
          advance = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
        end

        // Completed or dropped: chain straight into the next word if one is
        // buffered, giving one word per cycle under continuous ready.
        if (advance) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sel_d    = head_w[SEL_W+DW-1:DW];
            data_d   = head_w[DW-1:0];
            wait_d   = '0;
          end else begin
            strobe_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        strobe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      wait_q   <= '0;
      err_q    <= 1'b0;
      drop_q   <= '0;
      xfer_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      xfer_q   <= xfer_d;
    end
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
module tb_demux_dispatch_ctrl;

  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_dest;
  logic [7:0]  in_data;
  logic [2:0]  sel;
  logic        strobe;
  logic [7:0]  data_out;
  logic [7:0]  ch_valid;
  logic [7:0]  ch_ready;
  logic        err_timeout;
  logic [7:0]  drop_cnt;
  logic [15:0] xfer_cnt;

  always #5 clk = ~clk;

  demux_dispatch_ctrl #(
    .DW      (DW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dest     (in_dest),
    .in_data     (in_data),
    .sel         (sel),
    .strobe      (strobe),
    .data_out    (data_out),
    .ch_valid    (ch_valid),
    .ch_ready    (ch_ready),
    .err_timeout (err_timeout),
    .drop_cnt    (drop_cnt),
    .xfer_cnt    (xfer_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: a queue of buffered words plus the word on display.
  logic [10:0] m_q[$];
  bit          m_pres = 1'b0;
  int          m_dest = 0;
  int          m_data = 0;
  int          m_wait = 0;
  int          m_drop = 0;
  int          m_xfer = 0;
  bit          m_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_load();
    logic [10:0] w;
    w      = m_q.pop_front();
    m_dest = int'(w[10:8]);
    m_data = int'(w[7:0]);
    m_pres = 1'b1;
    m_wait = 0;
  endtask

  task automatic model_update();
    bit push;
    bit done;
    if (!rst_n) begin
      m_q.delete();
      m_pres = 1'b0;
      m_dest = 0;
      m_data = 0;
      m_wait = 0;
      m_drop = 0;
      m_xfer = 0;
      m_err  = 1'b0;
      return;
    end
    push  = in_valid && (m_q.size() < DEPTH);
    m_err = 1'b0;
    done  = 1'b0;
    if (!m_pres) begin
      if (m_q.size() > 0) m_load();
    end else begin
      if (ch_ready[m_dest]) begin
        m_xfer = (m_xfer + 1) % 65536;
        done   = 1'b1;
      end else if (TIMEOUT != 0 && m_wait == TIMEOUT - 1) begin
        m_err = 1'b1;
        if (m_drop < 255) m_drop++;
        done  = 1'b1;
      end else begin
        m_wait++;
      end
      if (done) begin
        if (m_q.size() > 0) m_load();
        else m_pres = 1'b0;
      end
    end
    if (push) m_q.push_back({in_dest, in_data});
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("strobe",      32'(strobe),      32'(m_pres));
      check("sel",         32'(sel),         32'(m_dest));
      check("data_out",    32'(data_out),    32'(m_data));
      check("ch_valid",    32'(ch_valid),    m_pres ? (32'd1 << m_dest) : 32'd0);
      check("in_ready",    32'(in_ready),    32'(m_q.size() < DEPTH));
      check("err_timeout", 32'(err_timeout), 32'(m_err));
      check("drop_cnt",    32'(drop_cnt),    32'(m_drop));
      check("xfer_cnt",    32'(xfer_cnt),    32'(m_xfer));
    end
  end

  initial begin
    int n;
    int pulses;
    int mode;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_dest  = '0;
    in_data  = '0;
    ch_ready = 8'hFF;
    @(negedge clk);
    tick();
    tick();
    chk_en = 1'b1;
    rst_n  = 1'b1;
    check("rst_strobe",   32'(strobe),   32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_xfer",     32'(xfer_cnt), 32'd0);
    check("rst_drop",     32'(drop_cnt), 32'd0);
    check("rst_ch_valid", 32'(ch_valid), 32'd0);

    // Single word to channel 5
    in_valid = 1'b1; in_dest = 3'd5; in_data = 8'hA5; ch_ready = 8'hFF;
    tick();
    in_valid = 1'b0;
    check("t1_no_bypass", 32'(strobe), 32'd0);
    tick();
    check("t1_strobe",   32'(strobe),   32'd1);
    check("t1_ch_valid", 32'(ch_valid), 32'h20);
    check("t1_data",     32'(data_out), 32'hA5);
    tick();
    check("t1_xfer",     32'(xfer_cnt), 32'd1);
    check("t1_idle",     32'(strobe),   32'd0);

    // Back-to-back words to channels 0..3
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_dest = 3'(i); in_data = 8'(8'h10 + i);
      tick();
      check("t2_in_ready", 32'(in_ready), 32'd1);
      if (i > 0) check("t2_ch_valid", 32'(ch_valid), 32'd1 << (i - 1));
    end
    in_valid = 1'b0;
    tick();
    check("t2_ch_valid_last", 32'(ch_valid), 32'h08);
    tick();
    tick();
    check("t2_xfer", 32'(xfer_cnt), 32'd5);

    // Backpressure fills output register plus FIFO
    ch_ready = 8'h00;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_dest = 3'(i); in_data = 8'(8'h40 + i);
      tick();
    end
    in_valid = 1'b0;
    check("t3_full", 32'(in_ready), 32'd0);
    ch_ready = 8'hFF;
    for (int i = 0; i < 8; i++) tick();
    check("t3_drained", 32'(xfer_cnt), 32'd10);

    // Timeout on channel 3, next word to channel 1 follows
    ch_ready = 8'hF7;
    in_valid = 1'b1; in_dest = 3'd3; in_data = 8'h3C;
    tick();
    in_dest = 3'd1; in_data = 8'h11;
    n = 0;
    while (n < 40) begin
      tick();
      in_valid = 1'b0;
      n++;
      if (err_timeout) break;
    end
    check("t4_err_latency", 32'(n), 32'd17);
    check("t4_drop",        32'(drop_cnt), 32'd1);
    check("t4_next_sel",    32'(sel),      32'd1);
    check("t4_next_data",   32'(data_out), 32'h11);
    tick();
    check("t4_single_pulse", 32'(err_timeout), 32'd0);

    // Reset in the middle of a send with two words queued
    ch_ready = 8'h00;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_dest = 3'(i + 2); in_data = 8'(8'h70 + i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_strobe",   32'(strobe),   32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_xfer",     32'(xfer_cnt), 32'd0);
    check("t5_drop",     32'(drop_cnt), 32'd0);
    ch_ready = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_valid", 32'(ch_valid), 32'd0);
    end

    // 300 forced timeouts
    ch_ready = 8'h00;
    pulses   = 0;
    n        = 0;
    while (pulses < 300 && n < 300 * 17 + 100) begin
      in_valid = 1'b1;
      in_dest  = 3'($urandom_range(0, 7));
      in_data  = 8'($urandom);
      tick();
      n++;
      if (err_timeout) pulses++;
    end
    in_valid = 1'b0;
    check("t6_pulses",   32'(pulses),   32'd300);
    check("t6_drop_sat", 32'(drop_cnt), 32'd255);
    ch_ready = 8'hFF;
    for (int i = 0; i < 8; i++) tick();

    // Randomized traffic with varying sink behaviour and occasional reset
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) mode = int'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      in_dest  = 3'($urandom_range(0, 7));
      in_data  = 8'($urandom);
      case (mode)
        0:       ch_ready = 8'hFF;
        1:       ch_ready = 8'($urandom);
        2:       ch_ready = 8'($urandom) & 8'($urandom) & 8'($urandom);
        default: ch_ready = 8'h00;
      endcase
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
